uart_rx_ovs: RTL and testbench

//  Parametrised 16550-style serial receiver. Oversamples rx at OVS x baud,

---
 rtl/uart_rx_ovs.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ovs.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ovs
// Description : 16550-style oversampling serial receiver. Synchronises rx,
//               rejects false start bits, assembles 5-8 bit LSB-first frames
//               and reports parity, framing and break status together with a
//               one-cycle push strobe towards the RX FIFO.
//               Build option: define UART_RX_MAJORITY_EN to decide each bit by
//               a 2-of-3 vote around mid-bit instead of a single sample.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ovs #(
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       rx,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky_parity,
    output logic       push,
    output logic [7:0] dout,
    output logic       pe,
    output logic       fe,
    output logic       bi,
    output logic       busy
);

    localparam int CW = $clog2(OVS);

    localparam logic [CW-1:0] c_cnt_last = CW'(OVS - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] c_cnt_s0   = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] c_cnt_s1   = CW'(OVS / 2);
    localparam logic [CW-1:0] c_cnt_d    = CW'(OVS / 2 + 1);
`else
    localparam logic [CW-1:0] c_cnt_d    = CW'(OVS / 2);
`endif

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_start    = 3'd1;
    localparam logic [2:0] c_st_data     = 3'd2;
    localparam logic [2:0] c_st_parity   = 3'd3;
    localparam logic [2:0] c_st_stop     = 3'd4;
    localparam logic [2:0] c_st_brk_wait = 3'd5;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_bitcnt;
    logic [7:0]             r_data;
    logic                   r_pbit;
    logic                   r_perr;
    logic [1:0]             r_wls;
    logic                   r_pen;
    logic                   r_eps;
    logic                   r_stick;
    logic                   r_push;
    logic [7:0]             r_dout;
    logic                   r_pe;
    logic                   r_fe;
    logic                   r_bi;

    logic                   w_rxs;
    logic                   w_bit;
    logic                   w_at_d;
    logic                   w_at_last;
    logic [2:0]             w_last_bit;
    logic                   w_x;
    logic                   w_perr;
    logic                   w_brk;
    logic                   w_push_evt;

    // Synchronised copy of rx; flops idle high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign w_rxs      = r_sync[SYNC_STAGES-1];
    assign w_at_d     = (r_cnt == c_cnt_d);
    assign w_at_last  = (r_cnt == c_cnt_last);
    // Index of the final data bit: word length 5..8 maps to 4..7.
    assign w_last_bit = {1'b1, r_wls};

`ifdef UART_RX_MAJORITY_EN
    logic r_s0;
    logic r_s1;

    // Capture the two samples preceding the decision point for the majority vote.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else if (baud_pulse) begin
            if (r_cnt == c_cnt_s0) r_s0 <= w_rxs;
            if (r_cnt == c_cnt_s1) r_s1 <= w_rxs;
        end
    end

    assign w_bit = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
`else
    assign w_bit = w_rxs;
`endif

    // Parity check: x is the XOR of data and received parity bit; sticky mode
    // expects a constant parity bit of ~eps.
    assign w_x    = (^r_data) ^ w_bit;
    assign w_perr = r_stick ? (r_eps ? w_bit : ~w_bit)
                            : (r_eps ? w_x   : ~w_x);
    // Break: all-zero data, zero (or absent) parity bit and a zero stop bit.
    assign w_brk  = (r_data == 8'h00) && (!r_pen || !r_pbit) && !w_bit;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; transitions are only evaluated on baud ticks.
    always_comb begin
        w_state_nxt = r_state;
        if (baud_pulse) begin
            case (r_state)
                c_st_idle: begin
                    if (!w_rxs) w_state_nxt = c_st_start;
                end
                c_st_start: begin
                    if (w_at_d && w_bit) w_state_nxt = c_st_idle;
                    else if (w_at_last)  w_state_nxt = c_st_data;
                end
                c_st_data: begin
                    if (w_at_last && (r_bitcnt == w_last_bit))
                        w_state_nxt = r_pen ? c_st_parity : c_st_stop;
                end
                c_st_parity: begin
                    if (w_at_last) w_state_nxt = c_st_stop;
                end
                c_st_stop: begin
                    if (w_at_d) w_state_nxt = w_brk ? c_st_brk_wait : c_st_idle;
                end
                c_st_brk_wait: begin
                    if (w_rxs) w_state_nxt = c_st_idle;
                end
                default: w_state_nxt = c_st_idle;
            endcase
        end
    end

    // FSM outputs: busy level and the frame-complete event.
    always_comb begin
        busy       = (r_state != c_st_idle);
        w_push_evt = baud_pulse && (r_state == c_st_stop) && w_at_d;
    end

    // Bit timing, shadow configuration and frame assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_data   <= '0;
            r_pbit   <= 1'b0;
            r_perr   <= 1'b0;
            r_wls    <= '0;
            r_pen    <= 1'b0;
            r_eps    <= 1'b0;
            r_stick  <= 1'b0;
        end else if (baud_pulse) begin
            if ((r_state == c_st_idle) || (w_state_nxt == c_st_idle) ||
                (w_state_nxt == c_st_brk_wait) || w_at_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            case (r_state)
                c_st_idle: begin
                    if (!w_rxs) begin
                        r_wls   <= wls;
                        r_pen   <= pen;
                        r_eps   <= eps;
                        r_stick <= sticky_parity;
                        r_data  <= '0;
                        r_pbit  <= 1'b0;
                        r_perr  <= 1'b0;
                    end
                end
                c_st_start: begin
                    if (w_at_last) r_bitcnt <= '0;
                end
                c_st_data: begin
                    if (w_at_d) r_data[r_bitcnt] <= w_bit;
                    if (w_at_last && (r_bitcnt != w_last_bit)) r_bitcnt <= r_bitcnt + 1'b1;
                end
                c_st_parity: begin
                    if (w_at_d) begin
                        r_pbit <= w_bit;
                        r_perr <= w_perr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status registers: updated with the push and held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_push <= 1'b0;
            r_dout <= '0;
            r_pe   <= 1'b0;
            r_fe   <= 1'b0;
            r_bi   <= 1'b0;
        end else begin
            r_push <= w_push_evt;
            if (w_push_evt) begin
                r_dout <= r_data;
                r_pe   <= r_pen & r_perr;
                r_fe   <= ~w_bit | w_brk;
                r_bi   <= w_brk;
            end
        end
    end

    assign push = r_push;
    assign dout = r_dout;
    assign pe   = r_pe;
    assign fe   = r_fe;
    assign bi   = r_bi;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ovs.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ovs
// Description : Scoreboard bench for uart_rx_ovs. Frames are driven bit by bit
//               at OVS clocks per bit; expected status is queued before each
//               frame and a monitor pops and compares on every push.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ovs;

    localparam int OVS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_pulse = 1'b1;
    logic       rx = 1'b1;
    logic [1:0] wls = 2'b11;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sticky_parity = 1'b0;
    logic       push;
    logic [7:0] dout;
    logic       pe;
    logic       fe;
    logic       bi;
    logic       busy;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bi;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    uart_rx_ovs #(.OVS(OVS), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_pulse    (baud_pulse),
        .rx            (rx),
        .wls           (wls),
        .pen           (pen),
        .eps           (eps),
        .sticky_parity (sticky_parity),
        .push          (push),
        .dout          (dout),
        .pe            (pe),
        .fe            (fe),
        .bi            (bi),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", name, act, req);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic e_pe, input logic e_fe, input logic e_bi);
        exp_t e;
        e.d  = d;
        e.pe = e_pe;
        e.fe = e_fe;
        e.bi = e_bi;
        exp_q.push_back(e);
    endtask

    // Monitor: every push must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (push) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_push: got push with dout=%02h expected no push", dout);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check8("dout", dout, e.d);
                check1("pe", pe, e.pe);
                check1("fe", fe, e.fe);
                check1("bi", bi, e.bi);
            end
        end
    end

    // Hold rx at b for n clocks; rx always changes 1 time unit after a rising edge.
    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame: start, wl data bits LSB first, optional parity, one stop bit.
    // scramble flips the configuration inputs during the frame.
    // gbit selects a data bit that gets a one-clock glitch at mid-bit (-1: none).
    task automatic send(input logic [7:0] d, input int wl, input logic par_en,
                        input logic pbit, input logic stopb, input bit scramble,
                        input int gbit);
        logic [1:0] s_wls;
        logic       s_pen, s_eps, s_st;
        s_wls = wls; s_pen = pen; s_eps = eps; s_st = sticky_parity;
        drive_bit(1'b0, OVS);
        if (scramble) begin
            wls = ~s_wls; pen = ~s_pen; eps = ~s_eps; sticky_parity = ~s_st;
        end
        for (int i = 0; i < wl; i++) begin
            if (i == gbit) begin
                drive_bit(d[i], 9);
                drive_bit(~d[i], 1);
                drive_bit(d[i], OVS - 10);
            end else begin
                drive_bit(d[i], OVS);
            end
        end
        if (par_en) drive_bit(pbit, OVS);
        drive_bit(stopb, OVS);
        wls = s_wls; pen = s_pen; eps = s_eps; sticky_parity = s_st;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check1("rst_push", push, 1'b0);
        check8("rst_dout", dout, 8'h00);
        check1("rst_pe", pe, 1'b0);
        check1("rst_fe", fe, 1'b0);
        check1("rst_bi", bi, 1'b0);
        check1("rst_busy", busy, 1'b0);
        rst = 1'b0;
        drive_bit(1'b1, 5);

        // 8N1 frame
        wls = 2'b11; pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0;
        expect_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        send(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        drive_bit(1'b1, 20);

        // 5-bit even parity: 0x13 has three ones, so parity 0 is wrong, 1 is right
        wls = 2'b00; pen = 1'b1; eps = 1'b1;
        expect_frame(8'h13, 1'b1, 1'b0, 1'b0);
        send(8'h13, 5, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        expect_frame(8'h13, 1'b0, 1'b0, 1'b0);
        send(8'h13, 5, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        drive_bit(1'b1, 20);

        // Sticky parity: eps=0 expects 1, eps=1 expects 0
        wls = 2'b11; pen = 1'b1; sticky_parity = 1'b1; eps = 1'b0;
        expect_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        send(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        eps = 1'b1;
        expect_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        send(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        drive_bit(1'b1, 20);

        // 6-bit frame with configuration flipped mid-frame: shadows must hold
        wls = 2'b01; pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0;
        expect_frame(8'h2A, 1'b0, 1'b0, 1'b0);
        send(8'h2A, 6, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        drive_bit(1'b1, 20);

        // Framing error on a non-zero word: fe without break
        wls = 2'b11;
        expect_frame(8'h81, 1'b0, 1'b1, 1'b0);
        send(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        drive_bit(1'b1, 40);

        // False start: 4 ticks low is rejected at mid-bit
        drive_bit(1'b0, 4);
        check1("glitch_busy_rise", busy, 1'b1);
        drive_bit(1'b1, 30);
        check1("glitch_busy_fall", busy, 1'b0);

        // Break: rx low for two whole frames gives exactly one push
        expect_frame(8'h00, 1'b0, 1'b1, 1'b1);
        drive_bit(1'b0, 2 * 10 * OVS);
        check1("brk_wait_busy", busy, 1'b1);
        drive_bit(1'b1, 10);
        check1("brk_release_busy", busy, 1'b0);
        drive_bit(1'b1, 20);

        // Back-to-back frames with a single stop bit
        expect_frame(8'h55, 1'b0, 1'b0, 1'b0);
        expect_frame(8'h0F, 1'b0, 1'b0, 1'b0);
        send(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        send(8'h0F, 8, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        drive_bit(1'b1, 20);

        // Reset in the middle of a frame: no push, outputs back to reset values
        drive_bit(1'b0, OVS);
        drive_bit(1'b1, OVS);
        drive_bit(1'b1, OVS);
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        #1;
        check8("midrst_dout", dout, 8'h00);
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_push", push, 1'b0);
        rst = 1'b0;
        drive_bit(1'b1, 200);

        // Recovery after reset
        expect_frame(8'hC3, 1'b0, 1'b0, 1'b0);
        send(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        drive_bit(1'b1, 20);

`ifdef UART_RX_MAJORITY_EN
        // One-clock glitch at mid-bit of data bit 0 is out-voted
        expect_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        send(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        drive_bit(1'b1, 20);
`endif

        drive_bit(1'b1, 40);
        check8("pending_expectations", 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
